scarv_cop_cpu_if: RTL and testbench

- COP-side responder for the CPU/COP instruction handshake.
- Accepts instructions and RS1 data from the CPU into a small in-order buffer and issues them to the COP decode/execute stage.
- Holds each execute result on the CPU response interface until the CPU acknowledges it.
- Handles abort, and drives the clock request from buffer and response occupancy.

---
 rtl/scarv_cop_cpu_if_if.sv | 39 +++
 rtl/scarv_cop_cpu_if.sv | 113 +++++++++++
 tb/tb_scarv_cop_cpu_if.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_cpu_if_if.sv
// Bundle of CPU/COP instruction handshake, decode-issue and execute-result
// signals. The slave side is the COP-side responder; the master side is its environment.
interface scarv_cop_cpu_if_if;
   logic        cpu_insn_req;
   logic        cop_insn_ack;
   logic        cpu_abort_req;
   logic [31:0] cpu_insn_enc;
   logic [31:0] cpu_rs1;
   logic        cop_wen;
   logic [4:0]  cop_waddr;
   logic [31:0] cop_wdata;
   logic [2:0]  cop_result;
   logic        cop_insn_rsp;
   logic        cpu_insn_ack;
   logic        id_valid;
   logic [31:0] id_insn_enc;
   logic [31:0] id_rs1;
   logic        id_ready;
   logic        ex_done;
   logic        ex_wen;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic [2:0]  ex_result;
   logic        ex_ready;

   modport slave (
      input  cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
      input  id_ready, ex_done, ex_wen, ex_waddr, ex_wdata, ex_result,
      output cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
      output id_valid, id_insn_enc, id_rs1, ex_ready
   );

   modport master (
      output cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
      output id_ready, ex_done, ex_wen, ex_waddr, ex_wdata, ex_result,
      input  cop_insn_ack, cop_wen, cop_waddr, cop_wdata, cop_result, cop_insn_rsp,
      input  id_valid, id_insn_enc, id_rs1, ex_ready
   );
endinterface

// File: rtl/scarv_cop_cpu_if.sv
// COP-side responder for the CPU/COP instruction handshake: small in-order
// instruction buffer feeding decode, plus a single held result slot.
module scarv_cop_cpu_if #(
   parameter int unsigned IBUF_DEPTH = 2,
   parameter int unsigned IBUF_PW    = 1
) (
   input  logic               g_clk,
   input  logic               g_resetn,
   output logic               g_clk_req,
   scarv_cop_cpu_if_if.slave  bus
);

   localparam logic [IBUF_PW:0] FullCount = (IBUF_PW + 1)'(IBUF_DEPTH);

   logic [IBUF_PW-1:0] rptr_q, rptr_d;
   logic [IBUF_PW-1:0] wptr_q, wptr_d;
   logic [IBUF_PW:0]   count_q, count_d;
   logic [63:0]        mem_q [IBUF_DEPTH];

   logic        rsp_valid_q, rsp_valid_d;
   logic        res_wen_q, res_wen_d;
   logic [4:0]  res_waddr_q, res_waddr_d;
   logic [31:0] res_wdata_q, res_wdata_d;
   logic [2:0]  res_result_q, res_result_d;

   logic push, pop, load;

   // Handshake decode; ack deliberately has no path from cpu_insn_req.
   always_comb begin
      bus.cop_insn_ack = g_resetn && (count_q != FullCount) && !bus.cpu_abort_req;
      bus.id_valid     = (count_q != '0);
      bus.id_insn_enc  = mem_q[rptr_q][63:32];
      bus.id_rs1       = mem_q[rptr_q][31:0];
      bus.ex_ready     = !rsp_valid_q || bus.cpu_insn_ack;
      bus.cop_insn_rsp = rsp_valid_q;
      bus.cop_wen      = res_wen_q;
      bus.cop_waddr    = res_waddr_q;
      bus.cop_wdata    = res_wdata_q;
      bus.cop_result   = res_result_q;
      g_clk_req        = g_resetn && ((count_q != '0) || rsp_valid_q || bus.cpu_insn_req);
      push             = bus.cpu_insn_req && bus.cop_insn_ack;
      // Abort flush wins over a pop in the same cycle.
      pop              = bus.id_valid && bus.id_ready && !bus.cpu_abort_req;
      load             = bus.ex_done && bus.ex_ready;
   end

   // Buffer pointer and occupancy next state.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (bus.cpu_abort_req) begin
         count_d = '0;
         rptr_d  = wptr_q;
      end else begin
         if (push) wptr_d = wptr_q + IBUF_PW'(1);
         if (pop)  rptr_d = rptr_q + IBUF_PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + (IBUF_PW + 1)'(1);
            2'b01:   count_d = count_q - (IBUF_PW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Result slot next state; a release and a new load on one edge gives no bubble.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      res_wen_d    = res_wen_q;
      res_waddr_d  = res_waddr_q;
      res_wdata_d  = res_wdata_q;
      res_result_d = res_result_q;
      if (load) begin
         rsp_valid_d  = 1'b1;
         res_wen_d    = bus.ex_wen;
         res_waddr_d  = bus.ex_waddr;
         res_wdata_d  = bus.ex_wdata;
         res_result_d = bus.ex_result;
      end else if (bus.cpu_insn_ack && rsp_valid_q) begin
         rsp_valid_d = 1'b0;
         res_wen_d   = 1'b0;
      end
   end

   // Control and result state registers.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         rptr_q       <= '0;
         wptr_q       <= '0;
         count_q      <= '0;
         rsp_valid_q  <= 1'b0;
         res_wen_q    <= 1'b0;
         res_waddr_q  <= '0;
         res_wdata_q  <= '0;
         res_result_q <= '0;
      end else begin
         rptr_q       <= rptr_d;
         wptr_q       <= wptr_d;
         count_q      <= count_d;
         rsp_valid_q  <= rsp_valid_d;
         res_wen_q    <= res_wen_d;
         res_waddr_q  <= res_waddr_d;
         res_wdata_q  <= res_wdata_d;
         res_result_q <= res_result_d;
      end
   end

   // Buffer payload; not reset, only read when occupancy says it is valid.
   always_ff @(posedge g_clk) begin
      if (push) mem_q[wptr_q] <= {bus.cpu_insn_enc, bus.cpu_rs1};
   end

endmodule

// File: tb/tb_scarv_cop_cpu_if.sv
// Randomised and directed bench for scarv_cop_cpu_if with a queue-based model.
module tb_scarv_cop_cpu_if;
   localparam int unsigned DEPTH = 2;

   logic g_clk = 1'b0;
   logic g_resetn = 1'b0;
   logic g_clk_req;
   bit   chk_en = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   scarv_cop_cpu_if_if bus ();

   scarv_cop_cpu_if #(.IBUF_DEPTH(DEPTH), .IBUF_PW(1)) dut (
      .g_clk     (g_clk),
      .g_resetn  (g_resetn),
      .g_clk_req (g_clk_req),
      .bus       (bus)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model state: buffered {enc, rs1} in order, plus the held result.
   logic [63:0] mq[$];
   logic        m_rv, m_wen;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic [2:0]  m_res;
   logic [31:0] popped[$];

   // Model update from the inputs seen at each rising edge.
   always @(posedge g_clk or negedge g_resetn) begin : model
      bit ack, push, pop, exr;
      if (!g_resetn) begin
         mq.delete();
         m_rv = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_res = 0;
      end else begin
         ack  = (mq.size() != DEPTH) && !bus.cpu_abort_req;
         push = bus.cpu_insn_req && ack;
         pop  = (mq.size() != 0) && bus.id_ready && !bus.cpu_abort_req;
         exr  = !m_rv || bus.cpu_insn_ack;
         if (bus.cpu_abort_req) mq.delete();
         else begin
            if (pop) begin
               popped.push_back(mq[0][63:32]);
               void'(mq.pop_front());
            end
            if (push) mq.push_back({bus.cpu_insn_enc, bus.cpu_rs1});
         end
         if (bus.ex_done && exr) begin
            m_rv = 1; m_wen = bus.ex_wen; m_waddr = bus.ex_waddr;
            m_wdata = bus.ex_wdata; m_res = bus.ex_result;
         end else if (bus.cpu_insn_ack && m_rv) begin
            m_rv = 0; m_wen = 0;
         end
      end
   end

   // Compare every cycle, mid-period, against the model.
   always @(negedge g_clk) begin
      if (chk_en && g_resetn) begin
         chk("ack", bus.cop_insn_ack, (mq.size() != DEPTH) && !bus.cpu_abort_req);
         chk("id_valid", bus.id_valid, mq.size() != 0);
         if (mq.size() != 0) chk("id_head", {bus.id_insn_enc, bus.id_rs1}, mq[0]);
         chk("rsp", bus.cop_insn_rsp, m_rv);
         chk("wen", bus.cop_wen, m_wen);
         chk("waddr", bus.cop_waddr, m_waddr);
         chk("wdata", bus.cop_wdata, m_wdata);
         chk("result", bus.cop_result, m_res);
         chk("ex_ready", bus.ex_ready, !m_rv || bus.cpu_insn_ack);
         chk("clk_req", g_clk_req, (mq.size() != 0) || m_rv || bus.cpu_insn_req);
      end
   end

   task automatic idle();
      bus.cpu_insn_req = 0; bus.cpu_abort_req = 0; bus.cpu_insn_enc = 0; bus.cpu_rs1 = 0;
      bus.cpu_insn_ack = 0; bus.id_ready = 0; bus.ex_done = 0; bus.ex_wen = 0;
      bus.ex_waddr = 0; bus.ex_wdata = 0; bus.ex_result = 0;
   endtask

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic ex_drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [2:0] res);
      bus.ex_done = 1; bus.ex_wen = wen; bus.ex_waddr = wa; bus.ex_wdata = wd;
      bus.ex_result = res;
   endtask

   initial begin
      int k;
      int cyc;
      idle();
      // In reset, a request must not produce an ack.
      bus.cpu_insn_req = 1;
      #2;
      chk("rst_ack", bus.cop_insn_ack, 0);
      chk("rst_clkreq", g_clk_req, 0);
      chk("rst_idv", bus.id_valid, 0);
      chk("rst_rsp", bus.cop_insn_rsp, 0);
      idle();
      @(negedge g_clk);
      g_resetn = 1;
      chk_en = 1;
      step();
      chk("init_ack", bus.cop_insn_ack, 1);
      chk("init_wdata", bus.cop_wdata, 0);
      chk("init_clkreq", g_clk_req, 0);

      // Single instruction through issue and response.
      bus.cpu_insn_req = 1; bus.cpu_insn_enc = 32'h0000_1234; bus.cpu_rs1 = 32'hDEAD_BEEF;
      bus.id_ready = 1;
      step();
      bus.cpu_insn_req = 0;
      chk("s_idv", bus.id_valid, 1);
      chk("s_enc", bus.id_insn_enc, 32'h0000_1234);
      chk("s_rs1", bus.id_rs1, 32'hDEAD_BEEF);
      step();
      chk("s_popped", bus.id_valid, 0);
      bus.id_ready = 0;
      ex_drive(1, 5, 32'hA5A5_A5A5, 0);
      step();
      bus.ex_done = 0;
      for (int i = 0; i < 3; i++) begin
         chk("s_rsp", bus.cop_insn_rsp, 1);
         chk("s_wdata", bus.cop_wdata, 32'hA5A5_A5A5);
         chk("s_waddr", bus.cop_waddr, 5);
         chk("s_exr_held", bus.ex_ready, 0);
         step();
      end
      bus.cpu_insn_ack = 1;
      step();
      bus.cpu_insn_ack = 0;
      chk("s_rel_rsp", bus.cop_insn_rsp, 0);
      chk("s_rel_wen", bus.cop_wen, 0);

      // Full buffer stalls the third request until the first pop.
      bus.cpu_insn_req = 1; bus.cpu_insn_enc = 1;
      step();
      bus.cpu_insn_enc = 2;
      chk("f_ack1", bus.cop_insn_ack, 1);
      step();
      chk("f_ack_full", bus.cop_insn_ack, 0);
      bus.cpu_insn_enc = 3;
      step();
      chk("f_stall", bus.cop_insn_ack, 0);
      chk("f_head1", bus.id_insn_enc, 1);
      bus.id_ready = 1;
      step();
      chk("f_head2", bus.id_insn_enc, 2);
      chk("f_ack_free", bus.cop_insn_ack, 1);
      step();
      bus.cpu_insn_req = 0;
      chk("f_head3", bus.id_insn_enc, 3);
      step();
      chk("f_empty", bus.id_valid, 0);
      bus.id_ready = 0;

      // Abort with two entries buffered and a held result.
      ex_drive(1, 7, 32'hCAFE_0001, 2);
      step();
      bus.ex_done = 0;
      bus.cpu_insn_req = 1; bus.cpu_insn_enc = 10;
      step();
      bus.cpu_insn_enc = 11;
      step();
      bus.cpu_insn_req = 0;
      chk("a_idv", bus.id_valid, 1);
      bus.cpu_abort_req = 1; bus.id_ready = 1;
      #1;
      chk("a_ack", bus.cop_insn_ack, 0);
      step();
      bus.cpu_abort_req = 0; bus.id_ready = 0;
      chk("a_flushed", bus.id_valid, 0);
      chk("a_rsp", bus.cop_insn_rsp, 1);
      chk("a_wdata", bus.cop_wdata, 32'hCAFE_0001);

      // Back-to-back responses.
      bus.cpu_insn_ack = 1;
      ex_drive(0, 3, 32'h1, 1);
      #1;
      chk("b_exr", bus.ex_ready, 1);
      step();
      bus.ex_done = 0;
      chk("b_rsp", bus.cop_insn_rsp, 1);
      chk("b_wdata", bus.cop_wdata, 32'h1);
      step();
      bus.cpu_insn_ack = 0;
      chk("b_rel", bus.cop_insn_rsp, 0);

      // Pointer wrap: ten entries 0..9 with random pops.
      popped.delete();
      k = 0;
      cyc = 0;
      while (popped.size() < 10 && cyc < 300) begin
         bus.cpu_insn_req = (k < 10);
         bus.cpu_insn_enc = k;
         bus.id_ready = 1'($urandom_range(0, 1));
         if (bus.cpu_insn_req && mq.size() != DEPTH) k++;
         step();
         cyc++;
      end
      idle();
      chk("w_count", popped.size(), 10);
      for (int i = 0; i < 10 && i < popped.size(); i++) chk("w_order", popped[i], i);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         bus.cpu_insn_req  = 1'($urandom_range(0, 1));
         bus.cpu_insn_enc  = $urandom;
         bus.cpu_rs1       = $urandom;
         bus.cpu_abort_req = ($urandom_range(0, 15) == 0);
         bus.id_ready      = 1'($urandom_range(0, 1));
         bus.cpu_insn_ack  = 1'($urandom_range(0, 1));
         bus.ex_done       = ($urandom_range(0, 9) < 3);
         bus.ex_wen        = 1'($urandom_range(0, 1));
         bus.ex_waddr      = 5'($urandom);
         bus.ex_wdata      = $urandom;
         bus.ex_result     = 3'($urandom);
         step();
      end
      idle();

      // Asynchronous reset mid-operation.
      bus.cpu_insn_ack = 1;
      ex_drive(1, 9, 32'h55, 4);
      step();
      idle();
      bus.cpu_insn_req = 1; bus.cpu_insn_enc = 32'h77;
      step();
      bus.cpu_insn_req = 0;
      chk("r_pre_idv", bus.id_valid, 1);
      chk("r_pre_rsp", bus.cop_insn_rsp, 1);
      #2;
      g_resetn = 0;
      #1;
      chk("r_ack", bus.cop_insn_ack, 0);
      chk("r_rsp", bus.cop_insn_rsp, 0);
      chk("r_wen", bus.cop_wen, 0);
      chk("r_waddr", bus.cop_waddr, 0);
      chk("r_wdata", bus.cop_wdata, 0);
      chk("r_result", bus.cop_result, 0);
      chk("r_idv", bus.id_valid, 0);
      chk("r_clkreq", g_clk_req, 0);
      @(negedge g_clk);
      #1;
      g_resetn = 1;
      step();
      chk("r_post_idv", bus.id_valid, 0);
      chk("r_post_rsp", bus.cop_insn_rsp, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
